// File: rtl/strip_feeder_if.sv
// Strip-input bus of the feature-map feeder: SRAM read port on one side,
// valid/ready strip stream toward the conv pipeline on the other.
interface strip_feeder_if #(
  parameter int PP_PAR = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic                       mem_rd_en;
  logic [ADDR_W-1:0]          mem_rd_addr;
  logic [PP_PAR*DATA_W-1:0]   mem_rd_data;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [PP_PAR*DATA_W-1:0]   dout_data;
  logic [15:0]                dout_col;
  logic [15:0]                dout_row;
  logic                       dout_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output dout_valid, dout_data, dout_col, dout_row, dout_last,
    input  dout_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  dout_valid, dout_data, dout_col, dout_row, dout_last,
    output dout_ready
  );
endinterface

// File: rtl/strip_feeder.sv
// Feeds an image from the feature-map SRAM to the conv pipeline as tagged
// strips in row-major order. Reads are credit-limited so that the 2-entry
// prefetch FIFO plus the single in-flight read never exceed two strips.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; configuration latched on start
// RUN   | issuing SRAM reads row by row as credit allows
// DRAIN | all reads issued; waiting for the last strip to be taken
// DONE  | frame complete; done held until start is low
module strip_feeder #(
  parameter int PP_PAR = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       img_width_strips,
  input  logic [15:0]       img_height,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              busy,
  output logic              done,
  strip_feeder_if.master    bus
);

  localparam int DW = PP_PAR * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [15:0]       width;
  logic [15:0]       height;
  logic [ADDR_W-1:0] stride;
  logic [15:0]       rd_col;
  logic [15:0]       rd_row;
  logic [ADDR_W-1:0] row_base;

  logic              inflight;
  logic [15:0]       inflight_col;
  logic [15:0]       inflight_row;

  logic [DW-1:0]     fifo_data [2];
  logic [15:0]       fifo_col  [2];
  logic [15:0]       fifo_row  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic              row_end;
  logic              frame_end;

  assign push      = inflight;
  assign pop       = bus.dout_valid && bus.dout_ready;
  // Strips already owed to the consumer, less the one leaving this cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && (occupancy < 3'd2);
  assign row_end   = (rd_col == width - 16'd1);
  assign frame_end = row_end && (rd_row == height - 16'd1);

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = row_base + ADDR_W'(rd_col);

  assign bus.dout_valid  = (fifo_count != 2'd0);
  assign bus.dout_data   = fifo_data[rd_ptr];
  assign bus.dout_col    = fifo_col[rd_ptr];
  assign bus.dout_row    = fifo_row[rd_ptr];
  assign bus.dout_last   = bus.dout_valid
                           && (fifo_row[rd_ptr] == height - 16'd1)
                           && (fifo_col[rd_ptr] == width - 16'd1);

  // Frame sequencing, read-address walk and busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      width    <= '0;
      height   <= '0;
      stride   <= '0;
      rd_col   <= '0;
      rd_row   <= '0;
      row_base <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            width    <= img_width_strips;
            height   <= img_height;
            stride   <= row_stride;
            rd_col   <= '0;
            rd_row   <= '0;
            row_base <= base_addr;
            if (img_width_strips == 16'd0 || img_height == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (row_end) begin
              rd_col   <= '0;
              rd_row   <= rd_row + 16'd1;
              row_base <= row_base + stride;
              if (frame_end) state <= DRAIN;
            end else begin
              rd_col <= rd_col + 16'd1;
            end
          end
        end
        DRAIN: begin
          // The last strip is the only one left once nothing is in flight,
          // so the FIFO emptying on this edge means it was just accepted.
          if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag of the read whose data returns next cycle; cleared by reset so a
  // read pending across reset is never pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      inflight_col <= '0;
      inflight_row <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_col <= rd_col;
        inflight_row <= rd_row;
      end
    end
  end

  // Two-entry prefetch FIFO holding returned strips with their tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_col[i]  <= '0;
        fifo_row[i]  <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.mem_rd_data;
        fifo_col[wr_ptr]  <= inflight_col;
        fifo_row[wr_ptr]  <= inflight_row;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/strip_feeder.md
# strip_feeder

Streams an image from the feature-map SRAM as PP_PAR-pixel strips into the conv pipeline's `din_valid`/`din_ready` port, in row-major order. It is the transmitter end of the strip-input handshake. It generates SRAM read addresses, absorbs the one-cycle read latency with a 2-entry prefetch FIFO, and tags each strip with its column and row. It tolerates the consumer's bursty ready pattern, where ready is high for one cycle and then drops.

## Interface
- PP_PAR, 8, pixels per strip
- DATA_W, 8, bits per pixel
- ADDR_W, 16, SRAM word address width; one word holds one strip
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  frame start; sampled only in IDLE
- img_width_strips  in  16  strips per row; latched at start
- img_height  in  16  rows per frame; latched at start
- base_addr  in  ADDR_W  word address of strip (0,0); latched at start
- row_stride  in  ADDR_W  word offset between rows; latched at start
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  ADDR_W  SRAM read address
- mem_rd_data  in  PP_PAR*DATA_W  read data, valid the cycle after mem_rd_en
- dout_valid  out  1  strip available
- dout_ready  in  1  consumer accepts
- dout_data  out  PP_PAR*DATA_W  strip payload
- dout_col  out  16  strip column index
- dout_row  out  16  strip row index
- dout_last  out  1  last strip of the frame
- busy  out  1  high from start acceptance until DONE
- done  out  1  frame complete; held until start is low

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `start`, latch the four configuration inputs.
  - Clear rd_col, rd_row, and row_base to base_addr.
  - If width==0 or height==0, go to DONE; otherwise go to RUN.
- RUN: issue reads in row-major order.
  - `mem_rd_addr` = row_base + rd_col, modulo 2^ADDR_W.
  - At the end of a row, rd_col returns to 0, rd_row increments, and row_base += row_stride (wraps modulo 2^ADDR_W).
  - A read issues only if `fifo_count + inflight - pop < 2`, where pop = dout_valid && dout_ready in the same cycle.
  - When the read for strip (h-1, w-1) issues, go to DRAIN.
- In-flight tags: each issued read carries its {col, row} in a 1-deep in-flight register. Data and tag are pushed into the FIFO together on the return cycle.
- DRAIN: no reads. Go to DONE when inflight==0, the FIFO is empty, and the last strip has been accepted.
- DONE: `done`=1 and `busy`=0. Return to IDLE when `start`==0.
- Output side:
  - `dout_*` present the FIFO head and `dout_valid` = !fifo_empty.
  - `dout_last` = (head row == h-1 && head col == w-1).
  - Push and pop in the same cycle keeps the count unchanged. A push never occurs when the FIFO is full; the credit rule guarantees this.
- `start` while busy or in DONE is ignored.

## Timing
- Reset values: mem_rd_en=0, mem_rd_addr=0, dout_valid=0, dout_data=0, dout_col=0, dout_row=0, dout_last=0, busy=0, done=0. The FIFO is empty and inflight=0.
- Reset mid-frame discards FIFO contents and any in-flight read. The returning data from that read is ignored.
- `start` sampled at edge E0 sets busy=1 in cycle 1.
- The first `mem_rd_en` is in cycle 1. Data returns in cycle 2 and is written at the end of cycle 2. `dout_valid`=1 in cycle 3, so start-to-first-valid latency is 3 cycles.
- With `dout_ready` held high, throughput is 1 strip per cycle after fill.
- With ready pulsing 1-high/1-low, the FIFO never overflows and no strip is dropped or duplicated.
- `dout_*` must stay stable while dout_valid=1 and dout_ready=0.
- done rises the cycle after the last strip is accepted (earliest). For a zero-size frame, done rises in cycle 1.

## Test plan
- w=2, h=3, base=0x10, stride=2, ready always 1 → addresses 0x10,0x11,0x12,0x13,0x14,0x15; six strips with (row,col) = (0,0)…(2,1); dout_last only on (2,1); first valid in cycle 3.
- Same frame with ready alternating 1/0 → identical strip sequence; each payload stable while stalled; fifo_count never exceeds 2.
- w=0, h=5 → no mem_rd_en, no dout_valid; done=1 in cycle 1; done clears after start drops.
- base=0xFFFE, stride=0x0001, w=1, h=4 → addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- rst_n low for 1 cycle after strip 3 of a 4x4 frame → all outputs 0; a new start replays from (0,0) with no stale data.
- start pulsed again mid-frame → ignored; the frame completes normally with exactly w*h strips.
